// File: rtl/lpc_io_target.sv
// lpc_io_target: LPC I/O target. Decodes host I/O read/write cycles inside a
// configurable address window, hands each accepted cycle to a local register
// port via a one-clock strobe and sticky ready handshake, and answers the host
// with long-wait SYNC while the local side is busy or error SYNC on timeout.
module lpc_io_target #(
  parameter logic [15:0] BASE_ADDR = 16'h0080,
  parameter logic [15:0] ADDR_MASK = 16'hFFF0,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lframe_i,
  input  logic [3:0]  lad_i,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  output logic [15:0] addr_o,
  output logic [7:0]  wdata_o,
  output logic        rd_o,
  output logic        wr_o,
  input  logic [7:0]  rdata_i,
  input  logic        ready_i,
  output logic        err_o,
  output logic [4:0]  state_o
);

  localparam int unsigned   CW         = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  localparam logic [3:0] NIB_START  = 4'b0000;
  localparam logic [3:0] CT_IO_RD   = 4'b0000;
  localparam logic [3:0] CT_IO_WR   = 4'b0010;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;
  localparam logic [3:0] NIB_TAR    = 4'b1111;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_CYCTYPE = 5'd1,
    ST_ADDR0   = 5'd2,
    ST_ADDR1   = 5'd3,
    ST_ADDR2   = 5'd4,
    ST_ADDR3   = 5'd5,
    ST_WDAT0   = 5'd6,
    ST_WDAT1   = 5'd7,
    ST_TAR1    = 5'd8,
    ST_TAR2    = 5'd9,
    ST_SYNC    = 5'd10,
    ST_RDAT0   = 5'd11,
    ST_RDAT1   = 5'd12,
    ST_PTAR    = 5'd13,
    ST_IGNORE  = 5'd14
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    lad_d;
  logic          oe_d, rd_d, wr_d, err_d;
  logic [15:0]   addr_d;
  logic [7:0]    wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          ready_q, ready_d;
  logic          write_q, write_d;
  logic          ready_now;
  logic [15:0]   addr_next;
  logic          addr_hit;

  assign state_o   = state_q;
  assign ready_now = ready_q | ready_i;
  assign addr_next = {addr_o[15:4], lad_i};
  assign addr_hit  = ((addr_next & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

  // Next-state and next-output decode; every LAD nibble and strobe is decided one clock ahead so outputs leave flops.
  always_comb begin
    state_d = state_q;
    lad_d   = NIB_TAR;
    oe_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_o;
    wdata_d = wdata_o;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    ready_d = ready_q;
    write_d = write_q;

    if (!lframe_i) begin
      if (lad_i == NIB_START) begin
        state_d = ST_CYCTYPE;
        wait_d  = '0;
        ready_d = 1'b0;
      end else if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_CYCTYPE: begin
          if (lad_i == CT_IO_RD) begin
            write_d = 1'b0;
            state_d = ST_ADDR0;
          end else if (lad_i == CT_IO_WR) begin
            write_d = 1'b1;
            state_d = ST_ADDR0;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_ADDR0: begin
          addr_d[15:12] = lad_i;
          state_d       = ST_ADDR1;
        end
        ST_ADDR1: begin
          addr_d[11:8] = lad_i;
          state_d      = ST_ADDR2;
        end
        ST_ADDR2: begin
          addr_d[7:4] = lad_i;
          state_d     = ST_ADDR3;
        end
        ST_ADDR3: begin
          addr_d = addr_next;
          if (!addr_hit) begin
            state_d = ST_IGNORE;
          end else if (write_q) begin
            state_d = ST_WDAT0;
          end else begin
            state_d = ST_TAR1;
            rd_d    = 1'b1;
          end
        end
        ST_WDAT0: begin
          wdata_d[3:0] = lad_i;
          state_d      = ST_WDAT1;
        end
        ST_WDAT1: begin
          wdata_d[7:4] = lad_i;
          state_d      = ST_TAR1;
          wr_d         = 1'b1;
        end
        ST_TAR1: begin
          if (ready_i && !ready_q) begin
            ready_d = 1'b1;
            rdata_d = rdata_i;
          end
          state_d = ST_TAR2;
        end
        ST_TAR2, ST_SYNC: begin
          if ((state_q == ST_SYNC) && (lad_o != SYNC_LWAIT)) begin
            oe_d = 1'b1;
            if (write_q) begin
              state_d = ST_PTAR;
              lad_d   = NIB_TAR;
            end else begin
              state_d = ST_RDAT0;
              lad_d   = rdata_q[3:0];
            end
          end else begin
            if (ready_i && !ready_q) begin
              ready_d = 1'b1;
              rdata_d = rdata_i;
            end
            state_d = ST_SYNC;
            oe_d    = 1'b1;
            if (ready_now) begin
              lad_d = SYNC_READY;
            end else if (wait_q == WAIT_LIMIT) begin
              lad_d   = SYNC_ERROR;
              err_d   = 1'b1;
              rdata_d = 8'hFF;
            end else begin
              lad_d  = SYNC_LWAIT;
              wait_d = wait_q + 1'b1;
            end
          end
        end
        ST_RDAT0: begin
          state_d = ST_RDAT1;
          oe_d    = 1'b1;
          lad_d   = rdata_q[7:4];
        end
        ST_RDAT1: begin
          state_d = ST_PTAR;
          oe_d    = 1'b1;
          lad_d   = NIB_TAR;
        end
        ST_PTAR:   state_d = ST_IDLE;
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State register and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      lad_o    <= 4'hF;
      lad_oe_o <= 1'b0;
      rd_o     <= 1'b0;
      wr_o     <= 1'b0;
      err_o    <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      rdata_q  <= '0;
      wait_q   <= '0;
      ready_q  <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lad_o    <= lad_d;
      lad_oe_o <= oe_d;
      rd_o     <= rd_d;
      wr_o     <= wr_d;
      err_o    <= err_d;
      addr_o   <= addr_d;
      wdata_o  <= wdata_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
      ready_q  <= ready_d;
      write_q  <= write_d;
    end
  end

endmodule

// File: tb/tb_lpc_io_target.sv
// tb_lpc_io_target: directed LPC host cycles against lpc_io_target. Stimulus
// pushes the expected strobe and LAD nibbles (with their cycle) into a queue;
// a forked monitor pops and compares whenever the target drives or strobes.
module tb_lpc_io_target;

  localparam logic [15:0] WIN_BASE = 16'h0080;
  localparam logic [15:0] WIN_MASK = 16'hFFF0;
  localparam int          WAIT_MAX = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lframe_i;
  logic [3:0]  lad_i;
  logic [3:0]  lad_o;
  logic        lad_oe_o;
  logic [15:0] addr_o;
  logic [7:0]  wdata_o;
  logic        rd_o;
  logic        wr_o;
  logic [7:0]  rdata_i;
  logic        ready_i;
  logic        err_o;
  logic [4:0]  state_o;

  lpc_io_target #(
    .BASE_ADDR(WIN_BASE),
    .ADDR_MASK(WIN_MASK),
    .MAX_WAIT (WAIT_MAX)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .lframe_i(lframe_i),
    .lad_i   (lad_i),
    .lad_o   (lad_o),
    .lad_oe_o(lad_oe_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rd_o    (rd_o),
    .wr_o    (wr_o),
    .rdata_i (rdata_i),
    .ready_i (ready_i),
    .err_o   (err_o),
    .state_o (state_o)
  );

  // Free-running LPC clock.
  always #5 clk_i = ~clk_i;

  // Absolute cycle index: after posedge N this holds N.
  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int          cyc;
    logic        rd;
    logic        wr;
    logic        err;
    logic        oe;
    logic [3:0]  lad;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_lad_oe"}, 32'(lad_oe_o), 32'h0);
    checkOutput({tag, "_lad"},    32'(lad_o),    32'hF);
    checkOutput({tag, "_rd"},     32'(rd_o),     32'h0);
    checkOutput({tag, "_wr"},     32'(wr_o),     32'h0);
    checkOutput({tag, "_err"},    32'(err_o),    32'h0);
    checkOutput({tag, "_addr"},   32'(addr_o),   32'h0);
    checkOutput({tag, "_wdata"},  32'(wdata_o),  32'h0);
    checkOutput({tag, "_state"},  32'(state_o),  32'h0);
  endtask

  function automatic void pushRec(input int base, input int rel, input int lim,
                                  input logic rd, input logic wr, input logic err,
                                  input logic oe, input logic [3:0] lad,
                                  input logic [15:0] addr, input logic [7:0] wdata);
    rec_t r;
    if (rel > lim) return;
    r.cyc = base + rel; r.rd = rd; r.wr = wr; r.err = err; r.oe = oe;
    r.lad = lad; r.addr = addr; r.wdata = wdata;
    exp_q.push_back(r);
  endfunction

  // rdy: 0 = ready tied high, -1 = never ready, k > 0 = ready from k cycles after the strobe.
  // abort_at >= 0: host stops driving this frame after rel abort_at-1; the next frame's START is the abort.
  task automatic applyStimulus(input bit is_wr, input logic [15:0] addr, input logic [7:0] data,
                               input int rdy, input int abort_at);
    int         base, s, w, t, last, lim, stop;
    bit         hit, tmo;
    logic [7:0] rd_val;
    @(posedge clk_i); #1;
    base   = cyc_cnt;
    hit    = ((addr & WIN_MASK) == (WIN_BASE & WIN_MASK));
    s      = is_wr ? 8 : 6;
    lim    = (abort_at >= 0) ? abort_at : 1000;
    if (rdy == 0)     w = 0;
    else if (rdy < 0) w = WAIT_MAX + 1;
    else              w = rdy - 1;
    tmo    = (w > WAIT_MAX);
    if (tmo) w = WAIT_MAX;
    rd_val = tmo ? 8'hFF : data;
    last   = 12;
    if (hit) begin
      pushRec(base, s, lim, !is_wr, is_wr, 1'b0, 1'b0, 4'hF, addr, data);
      t = s + 2;
      for (int i = 0; i < w; i++) pushRec(base, t + i, lim, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, addr, data);
      t = t + w;
      pushRec(base, t, lim, 1'b0, 1'b0, tmo, 1'b1, tmo ? 4'hA : 4'h0, addr, data);
      if (!is_wr) begin
        pushRec(base, t + 1, lim, 1'b0, 1'b0, 1'b0, 1'b1, rd_val[3:0], addr, data);
        pushRec(base, t + 2, lim, 1'b0, 1'b0, 1'b0, 1'b1, rd_val[7:4], addr, data);
        pushRec(base, t + 3, lim, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, addr, data);
        last = t + 3;
      end else begin
        pushRec(base, t + 1, lim, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, addr, data);
        last = t + 1;
      end
    end
    stop    = (abort_at >= 0) ? abort_at - 1 : last + 2;
    rdata_i = data;
    for (int rel = 0; rel <= stop; rel++) begin
      if (rel > 0) begin
        @(posedge clk_i); #1;
      end
      lframe_i = (rel != 0);
      case (rel)
        0:       lad_i = 4'h0;
        1:       lad_i = is_wr ? 4'h2 : 4'h0;
        2:       lad_i = addr[15:12];
        3:       lad_i = addr[11:8];
        4:       lad_i = addr[7:4];
        5:       lad_i = addr[3:0];
        6:       lad_i = is_wr ? data[3:0] : 4'hF;
        7:       lad_i = is_wr ? data[7:4] : 4'hF;
        default: lad_i = 4'hF;
      endcase
      ready_i = (rdy == 0) || ((rdy > 0) && (rel >= s + rdy));
    end
  endtask

  // Host starts a read, then reset is pulsed while the address is arriving.
  task automatic resetDuringAddr();
    @(posedge clk_i); #1;
    lframe_i = 1'b0; lad_i = 4'h0; ready_i = 1'b0;
    @(posedge clk_i); #1;
    lframe_i = 1'b1; lad_i = 4'h0;
    @(posedge clk_i); #1;
    lad_i = 4'hA;
    @(posedge clk_i); #1;
    lad_i = 4'h0;
    checkOutput("addr_preload", 32'(addr_o), 32'h0000A081);
    #2 rst_i = 1'b1;
    #1 checkResetOutputs("mid_addr_reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0; lframe_i = 1'b1; lad_i = 4'hF;
  endtask

  task automatic runMonitor();
    rec_t e;
    bit   ok;
    forever begin
      @(negedge clk_i);
      if (!rst_i && (rd_o || wr_o || err_o || lad_oe_o)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_output: got cyc=%0d rd=%b wr=%b err=%b oe=%b lad=%h, expected nothing queued",
                   cyc_cnt, rd_o, wr_o, err_o, lad_oe_o, lad_o);
        end else begin
          e  = exp_q.pop_front();
          ok = (cyc_cnt == e.cyc) && (rd_o === e.rd) && (wr_o === e.wr) && (err_o === e.err) &&
               (lad_oe_o === e.oe) && (lad_o === e.lad);
          if (e.rd || e.wr) ok = ok && (addr_o === e.addr);
          if (e.wr)         ok = ok && (wdata_o === e.wdata);
          if (ok) n_pass++;
          else $display("[TB] FAIL sb_cyc%0d: got cyc=%0d rd=%b wr=%b err=%b oe=%b lad=%h addr=%h wdata=%h, expected cyc=%0d rd=%b wr=%b err=%b oe=%b lad=%h addr=%h wdata=%h",
                        e.cyc, cyc_cnt, rd_o, wr_o, err_o, lad_oe_o, lad_o, addr_o, wdata_o,
                        e.cyc, e.rd, e.wr, e.err, e.oe, e.lad, e.addr, e.wdata);
        end
      end
    end
  endtask

  // Main sequence: reset, then directed host cycles, each followed by a drained-queue check.
  initial begin
    rst_i = 1'b1; lframe_i = 1'b1; lad_i = 4'hF; rdata_i = 8'h00; ready_i = 1'b0;
    fork
      runMonitor();
    join_none
    repeat (2) @(posedge clk_i);
    #1 checkResetOutputs("reset");
    rst_i = 1'b0;

    $display("[TB] read 0x0085, ready tied high");
    applyStimulus(1'b0, 16'h0085, 8'hA5, 0, -1);
    checkOutput("drain_read", 32'(exp_q.size()), 32'h0);

    $display("[TB] write 0x008F = 0x3C, ready tied high");
    applyStimulus(1'b1, 16'h008F, 8'h3C, 0, -1);
    checkOutput("drain_write", 32'(exp_q.size()), 32'h0);

    $display("[TB] read 0x0090 outside window");
    applyStimulus(1'b0, 16'h0090, 8'h77, 0, -1);
    checkOutput("drain_outside", 32'(exp_q.size()), 32'h0);

    $display("[TB] read 0x0083, ready 4 cycles after strobe");
    applyStimulus(1'b0, 16'h0083, 8'h5C, 4, -1);
    checkOutput("drain_wait4", 32'(exp_q.size()), 32'h0);

    $display("[TB] read 0x008A, ready never");
    applyStimulus(1'b0, 16'h008A, 8'h11, -1, -1);
    checkOutput("drain_timeout", 32'(exp_q.size()), 32'h0);

    $display("[TB] read 0x0084, ready on the timeout cycle");
    applyStimulus(1'b0, 16'h0084, 8'h3E, 9, -1);
    checkOutput("drain_ready_wins", 32'(exp_q.size()), 32'h0);

    $display("[TB] read 0x0081 aborted in SYNC wait, then write 0x0081 = 0x5A");
    applyStimulus(1'b0, 16'h0081, 8'hC3, -1, 11);
    applyStimulus(1'b1, 16'h0081, 8'h5A, 0, -1);
    checkOutput("drain_abort", 32'(exp_q.size()), 32'h0);

    $display("[TB] reset pulsed mid-address");
    resetDuringAddr();

    $display("[TB] read 0x0080 after reset");
    applyStimulus(1'b0, 16'h0080, 8'h96, 0, -1);
    checkOutput("drain_post_reset", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
